// File: rtl/sched_pkg.sv
// Shared types and encodings for the divergent per-core scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_REQUEST = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EXECUTE = 3'd5,
        ST_UPDATE  = 3'd6,
        ST_DONE    = 3'd7
    } core_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

endpackage

// File: rtl/scheduler_pc_select.sv
// Finds the lowest PC among pending threads and the group of threads sitting at it.
module scheduler_pc_select #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8
) (
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] thread_pc,
    input  logic [THREADS_PER_BLOCK-1:0]         pending,
    output logic [PC_BITS-1:0]                   min_pc_c,
    output logic [THREADS_PER_BLOCK-1:0]         group_mask_c,
    output logic                                 any_pending_c
);

    logic [PC_BITS-1:0] best;
    logic               found;

    // Linear min reduction; the first pending thread seeds the running minimum.
    always_comb begin
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < int'(THREADS_PER_BLOCK); i++) begin
            if (pending[i] && (!found || (thread_pc[i*PC_BITS +: PC_BITS] < best))) begin
                best  = thread_pc[i*PC_BITS +: PC_BITS];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        group_mask_c = '0;
        for (int i = 0; i < int'(THREADS_PER_BLOCK); i++) begin
            group_mask_c[i] = pending[i] && (thread_pc[i*PC_BITS +: PC_BITS] == best);
        end
    end

    assign min_pc_c      = best;
    assign any_pending_c = found;

endmodule

// File: rtl/divergent_scheduler.sv
// Per-core control FSM with per-thread PCs; reconverges divergent threads by always issuing the minimum PC.
module divergent_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8,
    parameter int unsigned TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [TC_BITS-1:0]                   thread_count,
    input  logic                                 decoded_mem_read_enable,
    input  logic                                 decoded_mem_write_enable,
    input  logic                                 decoded_ret,
    input  logic [2:0]                           fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
    output logic [2:0]                           core_state,
    output logic                                 done
);

    localparam int unsigned T  = THREADS_PER_BLOCK;
    localparam int unsigned PW = PC_BITS * THREADS_PER_BLOCK;

    core_state_t     state_q, state_d;
    logic [PC_BITS-1:0] current_pc_q, current_pc_d;
    logic [T-1:0]    enable_q, enable_d;
    logic            done_q, done_d;
    logic [PW-1:0]   thread_pc_q, thread_pc_d, thread_pc_upd;
    logic [T-1:0]    finished_q, finished_d, finished_upd;

    logic [T-1:0]       live;
    logic               lsu_busy;
    logic [PC_BITS-1:0] sel_min_pc;
    logic [T-1:0]       sel_group;
    logic               sel_any;

    // Memory-op flags are informational only; the LSU states already gate WAIT.
    logic unused_mem_flags;
    assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

    always_comb begin
        live = '0;
        for (int i = 0; i < int'(T); i++) begin
            live[i] = 32'(thread_count) > 32'(i);
        end
    end

    // Only enabled threads can hold the core in WAIT.
    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < int'(T); i++) begin
            if (enable_q[i] && ((lsu_state[2*i +: 2] == LSU_REQUESTING) ||
                                (lsu_state[2*i +: 2] == LSU_WAITING))) begin
                lsu_busy = 1'b1;
            end
        end
    end

    // Post-UPDATE per-thread view, used both for commit and for next-PC selection.
    always_comb begin
        thread_pc_upd = thread_pc_q;
        finished_upd  = finished_q;
        for (int i = 0; i < int'(T); i++) begin
            if (enable_q[i]) begin
                if (decoded_ret) begin
                    finished_upd[i] = 1'b1;
                end else begin
                    thread_pc_upd[i*PC_BITS +: PC_BITS] = next_pc[i*PC_BITS +: PC_BITS];
                end
            end
        end
    end

    scheduler_pc_select #(
        .THREADS_PER_BLOCK (T),
        .PC_BITS           (PC_BITS)
    ) u_pc_select (
        .thread_pc     (thread_pc_upd),
        .pending       (~finished_upd),
        .min_pc_c      (sel_min_pc),
        .group_mask_c  (sel_group),
        .any_pending_c (sel_any)
    );

    always_comb begin
        state_d      = state_q;
        current_pc_d = current_pc_q;
        enable_d     = enable_q;
        done_d       = done_q;
        thread_pc_d  = thread_pc_q;
        finished_d   = finished_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    finished_d  = ~live;
                    thread_pc_d = '0;
                    if (|live) begin
                        current_pc_d = '0;
                        enable_d     = live;
                        state_d      = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) state_d = ST_DECODE;
            end
            ST_DECODE:  state_d = ST_REQUEST;
            ST_REQUEST: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!lsu_busy) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: state_d = ST_UPDATE;
            ST_UPDATE: begin
                thread_pc_d = thread_pc_upd;
                finished_d  = finished_upd;
                if (!sel_any) begin
                    done_d   = 1'b1;
                    enable_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    current_pc_d = sel_min_pc;
                    enable_d     = sel_group;
                    state_d      = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            current_pc_q <= '0;
            enable_q     <= '0;
            done_q       <= 1'b0;
            thread_pc_q  <= '0;
            finished_q   <= '1;
        end else begin
            state_q      <= state_d;
            current_pc_q <= current_pc_d;
            enable_q     <= enable_d;
            done_q       <= done_d;
            thread_pc_q  <= thread_pc_d;
            finished_q   <= finished_d;
        end
    end

    assign current_pc    = current_pc_q;
    assign thread_enable = enable_q;
    assign core_state    = 3'(state_q);
    assign done          = done_q;

endmodule
